// File: rtl/pitch_stabilizer.sv
// Pitch stabilizer: locks onto a steady FFT peak bin; optional 4-tap averaging under PITCH_AVG_EN.
// Latency: out_valid/out_data follow the triggering sample (or idle timeout) by one clk edge.
// Backpressure: none; every in_valid strobe is consumed in its cycle, out_valid is a one-cycle strobe.
module pitch_stabilizer #(
    parameter int BW             = 10,
    parameter int STABLE_COUNT   = 3,
    parameter int TOL            = 2,
    parameter int MIN_BIN        = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [BW-1:0] in_data,
    output logic          out_valid,
    output logic [BW-1:0] out_data,
    output logic          locked
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] TRACK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam int CW = $clog2(STABLE_COUNT + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    state;
    logic [BW-1:0] cand;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idle_cnt;

    logic          accept;
    logic          match;
    logic          reload;
    logic          matching;
    logic          timeout_hit;
    logic [BW:0]   diff;
    logic [CW-1:0] cnt_inc;
    logic [BW-1:0] result;

    always_comb begin
        accept = in_valid && (in_data >= BW'(MIN_BIN));
        // Extra bit keeps the absolute difference from wrapping at the top of the bin range.
        if (in_data >= cand)
            diff = {1'b0, in_data} - {1'b0, cand};
        else
            diff = {1'b0, cand} - {1'b0, in_data};
        match       = (diff <= (BW+1)'(TOL));
        reload      = accept && ((state == IDLE) || !match);
        matching    = accept && (state != IDLE) && match;
        cnt_inc     = (cnt == CW'(STABLE_COUNT)) ? cnt : cnt + CW'(1);
        timeout_hit = !in_valid && (state != IDLE) && (idle_cnt == IW'(TIMEOUT_CYCLES - 1));
    end

`ifdef PITCH_AVG_EN
    logic [BW-1:0] hist1, hist2, hist3;
    logic [BW+1:0] sum;

    // Oldest entry drops out, so the output average uses the three newest plus this sample.
    always_comb begin
        sum    = {2'b00, hist1} + {2'b00, hist2} + {2'b00, hist3} + {2'b00, in_data};
        result = sum[BW+1:2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist1 <= '0;
            hist2 <= '0;
            hist3 <= '0;
        end else if (reload) begin
            hist1 <= in_data;
            hist2 <= in_data;
            hist3 <= in_data;
        end else if (matching) begin
            hist1 <= hist2;
            hist2 <= hist3;
            hist3 <= in_data;
        end
    end
`else
    always_comb result = in_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            idle_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            locked    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            // Discarded low bins freeze the idle counter as well as everything else.
            if (accept)
                idle_cnt <= '0;
            else if (!in_valid && (idle_cnt != IW'(TIMEOUT_CYCLES)))
                idle_cnt <= idle_cnt + IW'(1);

            if (reload) begin
                cand   <= in_data;
                cnt    <= CW'(1);
                state  <= TRACK;
                locked <= 1'b0;
            end else if (matching) begin
                cnt <= cnt_inc;
                if ((state == LOCKED) || (cnt_inc == CW'(STABLE_COUNT))) begin
                    state     <= LOCKED;
                    locked    <= 1'b1;
                    out_valid <= 1'b1;
                    out_data  <= result;
                end
            end else if (timeout_hit) begin
                state     <= IDLE;
                cnt       <= '0;
                locked    <= 1'b0;
                out_valid <= 1'b1;
                out_data  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pitch_stabilizer.sv
// Directed self-checking bench for pitch_stabilizer (default build, timeout shortened to 16 cycles).
module tb_pitch_stabilizer;

    localparam int BW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic          locked;

    int checks   = 0;
    int failures = 0;

    logic          ov;
    logic          lk;
    logic [BW-1:0] od;

    always #5 clk = ~clk;

    pitch_stabilizer #(
        .BW(BW), .STABLE_COUNT(3), .TOL(2), .MIN_BIN(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .locked(locked)
    );

    // Called at a negedge; presents one sample for one cycle and captures the result after the edge.
    task automatic send(input logic [BW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        ov = out_valid;
        od = out_data;
        lk = locked;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_async_data got=%0d exp=0", out_data); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst_async_locked got=%0b exp=0", locked); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%0d exp=0", out_data); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0b exp=0", locked); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_lock();
        send(10'd100);
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL lock_s1_valid got=%0b exp=0", ov); end
        send(10'd101);
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL lock_s2_valid got=%0b exp=0", ov); end
        send(10'd99);
        checks++; if (ov !== 1'b1) begin failures++; $display("FAIL lock_s3_valid got=%0b exp=1", ov); end
        checks++; if (od !== 10'd99) begin failures++; $display("FAIL lock_s3_data got=%0d exp=99", od); end
        checks++; if (lk !== 1'b1) begin failures++; $display("FAIL lock_s3_locked got=%0b exp=1", lk); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lock_pulse_width got=%0b exp=0", out_valid); end
        @(negedge clk);
    endtask

    task automatic test_unlock_relock();
        send(10'd100);
        checks++; if (ov !== 1'b1 || od !== 10'd100) begin failures++; $display("FAIL locked_match got=%0b/%0d exp=1/100", ov, od); end
        send(10'd110);
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL unlock_valid got=%0b exp=0", ov); end
        checks++; if (lk !== 1'b0) begin failures++; $display("FAIL unlock_locked got=%0b exp=0", lk); end
        checks++; if (od !== 10'd100) begin failures++; $display("FAIL unlock_hold got=%0d exp=100", od); end
        send(10'd110);
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL relock_s2_valid got=%0b exp=0", ov); end
        send(10'd111);
        checks++; if (ov !== 1'b1 || od !== 10'd111 || lk !== 1'b1) begin failures++; $display("FAIL relock got=%0b/%0d/%0b exp=1/111/1", ov, od, lk); end
    endtask

    task automatic test_discard();
        do_reset();
        send(10'd100);
        send(10'd0);
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL discard_0_valid got=%0b exp=0", ov); end
        send(10'd1);
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL discard_1_valid got=%0b exp=0", ov); end
        send(10'd101);
        checks++; if (ov !== 1'b0 || lk !== 1'b0) begin failures++; $display("FAIL discard_s4 got=%0b/%0b exp=0/0", ov, lk); end
        send(10'd100);
        checks++; if (ov !== 1'b1 || od !== 10'd100 || lk !== 1'b1) begin failures++; $display("FAIL discard_lock got=%0b/%0d/%0b exp=1/100/1", ov, od, lk); end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int first  = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL timeout_pulses got=%0d exp=1", pulses); end
        checks++; if (first !== 16) begin failures++; $display("FAIL timeout_cycle got=%0d exp=16", first); end
        checks++; if (out_data !== '0 || locked !== 1'b0) begin failures++; $display("FAIL timeout_state got=%0d/%0b exp=0/0", out_data, locked); end
        @(negedge clk);
        send(10'd100);
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL idle_s1_valid got=%0b exp=0", ov); end
        send(10'd100);
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL idle_s2_valid got=%0b exp=0", ov); end
        send(10'd100);
        checks++; if (ov !== 1'b1 || od !== 10'd100 || lk !== 1'b1) begin failures++; $display("FAIL idle_relock got=%0b/%0d/%0b exp=1/100/1", ov, od, lk); end
    endtask

    task automatic test_timeout_priority();
        int pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) pulses++;
        end
        send(10'd101);
        checks++; if (pulses !== 0) begin failures++; $display("FAIL prio_early_pulse got=%0d exp=0", pulses); end
        checks++; if (ov !== 1'b1 || od !== 10'd101 || lk !== 1'b1) begin failures++; $display("FAIL prio_sample got=%0b/%0d/%0b exp=1/101/1", ov, od, lk); end
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0 || locked !== 1'b1) begin failures++; $display("FAIL prio_after got=%0d/%0b exp=0/1", pulses, locked); end
    endtask

    task automatic test_nomatch();
        do_reset();
        send(10'd100);
        send(10'd102);
        send(10'd104);
        checks++; if (ov !== 1'b0 || lk !== 1'b0) begin failures++; $display("FAIL nomatch_104 got=%0b/%0b exp=0/0", ov, lk); end
        send(10'd104);
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL nomatch_restart got=%0b exp=0", ov); end
        send(10'd104);
        checks++; if (ov !== 1'b1 || od !== 10'd104) begin failures++; $display("FAIL nomatch_lock got=%0b/%0d exp=1/104", ov, od); end
        do_reset();
        send(10'd1023);
        send(10'd1021);
        send(10'd2);
        checks++; if (ov !== 1'b0 || lk !== 1'b0) begin failures++; $display("FAIL wrap_2 got=%0b/%0b exp=0/0", ov, lk); end
        send(10'd2);
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL wrap_2b got=%0b exp=0", ov); end
        send(10'd4);
        checks++; if (ov !== 1'b1 || od !== 10'd4 || lk !== 1'b1) begin failures++; $display("FAIL tol_edge got=%0b/%0d/%0b exp=1/4/1", ov, od, lk); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        send(10'd50);
        send(10'd50);
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL mid_pre_valid got=%0b exp=0", ov); end
        do_reset();
        send(10'd50);
        checks++; if (ov !== 1'b0 || lk !== 1'b0) begin failures++; $display("FAIL mid_s1 got=%0b/%0b exp=0/0", ov, lk); end
        send(10'd50);
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL mid_s2 got=%0b exp=0", ov); end
        send(10'd50);
        checks++; if (ov !== 1'b1 || od !== 10'd50 || lk !== 1'b1) begin failures++; $display("FAIL mid_lock got=%0b/%0d/%0b exp=1/50/1", ov, od, lk); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_unlock_relock();
        test_discard();
        test_timeout();
        test_timeout_priority();
        test_nomatch();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
